// File: rtl/e203_ifu_flush_ctrl_pkg.sv
// Shared constants for the IFU flush controller: FSM encoding, default outstanding depth, counter width helper.
package e203_ifu_flush_pkg;

  typedef enum logic [1:0] {
    FLS_IDLE  = 2'd0,
    FLS_DRAIN = 2'd1,
    FLS_PEND  = 2'd2
  } fls_state_e;

  localparam int OUTS_MAX_DEF = 2;

  // Bits needed to hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/e203_ifu_flush_ctrl_if.sv
// Commit-flush, fetch-handshake and redirect signals of the IFU flush controller.
interface e203_ifu_flush_ctrl_if #(
  parameter int PC_SIZE = 32
);
  logic               flush_req_i;
  logic               flush_ack_o;
  logic [PC_SIZE-1:0] flush_add_op1_i;
  logic [PC_SIZE-1:0] flush_add_op2_i;
  logic               fetch_req_hsk_i;
  logic               fetch_rsp_hsk_i;
  logic               rsp_drop_o;
  logic               ifu_halt_o;
  logic               redirect_valid_o;
  logic               redirect_ready_i;
  logic [PC_SIZE-1:0] redirect_pc_o;

  modport master (
    output flush_req_i, flush_add_op1_i, flush_add_op2_i,
           fetch_req_hsk_i, fetch_rsp_hsk_i, redirect_ready_i,
    input  flush_ack_o, rsp_drop_o, ifu_halt_o, redirect_valid_o, redirect_pc_o
  );

  modport slave (
    input  flush_req_i, flush_add_op1_i, flush_add_op2_i,
           fetch_req_hsk_i, fetch_rsp_hsk_i, redirect_ready_i,
    output flush_ack_o, rsp_drop_o, ifu_halt_o, redirect_valid_o, redirect_pc_o
  );
endinterface

// File: rtl/e203_ifu_flush_ctrl_outs_cnt.sv
// Up/down counter of outstanding IFU fetch requests; exposes the next-cycle value as a snapshot.
module e203_ifu_outs_cnt
  import e203_ifu_flush_pkg::*;
#(
  parameter int OUTS_MAX = OUTS_MAX_DEF,
  localparam int CW = cnt_w(OUTS_MAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt_next
);

  logic [CW-1:0] cnt;

  assign cnt_next = cnt + {{(CW-1){1'b0}}, inc} - {{(CW-1){1'b0}}, dec};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  // Over/underflow means the fetch side broke its request/response pairing.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(inc && !dec && (cnt == CW'(OUTS_MAX))));
      assert (!(dec && !inc && (cnt == '0)));
    end
  end

endmodule

// File: rtl/e203_ifu_flush_ctrl.sv
// IFU flush consumer: accepts commit flushes, drops stale fetch responses, then issues one registered redirect.
// Optional E203_FLUSH_STAT_EN adds flush_cnt_o / drop_cnt_tot_o statistics counters.
module e203_ifu_flush_ctrl
  import e203_ifu_flush_pkg::*;
#(
  parameter int PC_SIZE  = 32,
  parameter int OUTS_MAX = OUTS_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  e203_ifu_flush_ctrl_if.slave bus
`ifdef E203_FLUSH_STAT_EN
  ,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] drop_cnt_tot_o
`endif
);

  localparam int CW = cnt_w(OUTS_MAX);

  fls_state_e         state, state_nxt;
  logic [CW-1:0]      out_cnt_next;
  logic [CW-1:0]      drop_cnt, drop_cnt_next;
  logic [PC_SIZE-1:0] pend_pc, sum, tgt;
  logic               accept, fetch_inc, rsp_drop;

  assign accept    = bus.flush_req_i & rst_n;
  // A fetch racing with the flush belongs to the old stream and is not counted.
  assign fetch_inc = bus.fetch_req_hsk_i & ~bus.flush_req_i;
  assign rsp_drop  = bus.fetch_rsp_hsk_i & rst_n & (drop_cnt != '0);

  assign sum = bus.flush_add_op1_i + bus.flush_add_op2_i;
  assign tgt = {sum[PC_SIZE-1:1], 1'b0};

  e203_ifu_outs_cnt #(.OUTS_MAX(OUTS_MAX)) u_outs_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (fetch_inc),
    .dec      (bus.fetch_rsp_hsk_i),
    .cnt_next (out_cnt_next)
  );

  always_comb begin
    drop_cnt_next = drop_cnt;
    if (accept) begin
      drop_cnt_next = out_cnt_next;
    end else if (rsp_drop) begin
      drop_cnt_next = drop_cnt - CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = (drop_cnt_next != '0) ? FLS_DRAIN : FLS_PEND;
    end else begin
      case (state)
        FLS_DRAIN: if ((drop_cnt == CW'(1)) && bus.fetch_rsp_hsk_i) state_nxt = FLS_PEND;
        FLS_PEND:  if (bus.redirect_ready_i) state_nxt = FLS_IDLE;
        default:   state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FLS_IDLE;
      drop_cnt <= '0;
      pend_pc  <= '0;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_cnt_next;
      if (accept) begin
        pend_pc <= tgt;
      end
    end
  end

  assign bus.flush_ack_o      = accept;
  assign bus.rsp_drop_o       = rsp_drop;
  assign bus.ifu_halt_o       = (state != FLS_IDLE) | bus.flush_req_i;
  assign bus.redirect_valid_o = (state == FLS_PEND);
  assign bus.redirect_pc_o    = pend_pc;

`ifdef E203_FLUSH_STAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_cnt_o    <= '0;
      drop_cnt_tot_o <= '0;
    end else begin
      if (accept)   flush_cnt_o    <= flush_cnt_o + 32'd1;
      if (rsp_drop) drop_cnt_tot_o <= drop_cnt_tot_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/e203_ifu_flush_ctrl.md
Name: e203_ifu_flush_ctrl

Overview:
- IFU-side consumer of the commit-stage flush request.
- Merges branch-mispredict, fence.i, mret/dret and exception/IRQ flushes, all arriving on one add_op1/add_op2 request.
- Computes the redirect PC and acknowledges commit in the same cycle.
- Discards in-flight fetch responses made stale by the flush, then issues one registered redirect to the IFU fetch request path.

Parameters:
- PC_SIZE, 32, width of PC and adder operands.
- OUTS_MAX, 2, max outstanding IFU fetch requests; drain counter width = clog2(OUTS_MAX+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush_req_i  in  1  flush request from commit (branch resolve or non-ALU exception path)
- flush_ack_o  out  1  flush accepted this cycle
- flush_add_op1_i  in  PC_SIZE  target base (PC, EPC, DPC or trap vector)
- flush_add_op2_i  in  PC_SIZE  target offset (imm, 2, 4 or 0)
- fetch_req_hsk_i  in  1  IFU issued a normal fetch request this cycle
- fetch_rsp_hsk_i  in  1  a fetch response is consumed this cycle
- rsp_drop_o  out  1  the current response is stale and must be discarded
- ifu_halt_o  out  1  block normal fetch issue; high in DRAIN/PEND or while flush_req_i is high
- redirect_valid_o  out  1  redirect request to fetch
- redirect_ready_i  in  1  fetch accepts redirect
- redirect_pc_o  out  PC_SIZE  redirect target

Behaviour:
- Reset is rst_n, synchronous, active-low; clock is clk. Reset values:
  - state=IDLE; out_cnt=0; drop_cnt=0; pend_pc=0.
  - Outputs: redirect_valid_o=0, rsp_drop_o=0, flush_ack_o=0.
- flush_ack_o = flush_req_i & rst_n. Every flush is accepted in one cycle, in any state.
- Target arithmetic: tgt = (op1 + op2) mod 2^PC_SIZE, with bit0 forced to 0. Wrap-around is silent.
- On accept:
  - pend_pc <= tgt.
  - drop_cnt <= out_cnt_next, i.e. out_cnt + fetch_req_hsk_i − fetch_rsp_hsk_i, with fetch_req_hsk_i treated as 0 while flush_req_i is high.
  - A response consumed in the same cycle is dropped if drop_cnt>0, otherwise it is delivered.
- out_cnt: increments on fetch_req_hsk_i, decrements on fetch_rsp_hsk_i; both together leave it unchanged. Saturation beyond OUTS_MAX or below 0 is an assertion error.
- rsp_drop_o = fetch_rsp_hsk_i & (drop_cnt != 0). drop_cnt decrements on each dropped response.
- FSM states:
  - IDLE: redirect_valid_o=0.
  - DRAIN: waiting for stale responses to drain.
  - PEND: redirect_valid_o=1, redirect_pc_o=pend_pc.
- FSM transitions:
  - IDLE --accept--> DRAIN if drop_cnt_next != 0, else PEND.
  - DRAIN --(drop_cnt==1 & fetch_rsp_hsk_i)--> PEND.
  - PEND --(redirect_ready_i & no new accept)--> IDLE.
  - An accept in DRAIN or PEND overrides pend_pc (the youngest flush wins) and re-evaluates DRAIN/PEND. In PEND, a same-cycle ready and accept: the redirect handshake completes with the old pend_pc, the new target is loaded, and the FSM stays in PEND.
- Latency: flush accepted in cycle N with no outstanding requests → redirect_valid_o high in N+1. Each outstanding request adds one cycle per response latency.
- redirect_pc_o is stable while redirect_valid_o=1 and no new accept occurs.
- Reset mid-DRAIN/PEND: everything returns to reset values; no redirect is issued.

Optional Feature:
- E203_FLUSH_STAT_EN.
- Defined: adds 32-bit counters flush_cnt_o (accepted flushes) and drop_cnt_tot_o (dropped responses), reset to 0 and wrapping at 2^32. The ports exist only when defined.
- Undefined: no counters and no ports; behaviour is otherwise identical.

Decomposition:
- Shared package e203_ifu_flush_pkg holds:
  - state encoding localparams FLS_IDLE=2'd0, FLS_DRAIN=2'd1, FLS_PEND=2'd2;
  - the OUTS_MAX default;
  - the counter-width function.
- One natural sub-module: e203_ifu_outs_cnt, an up/down outstanding counter with snapshot output.

Test Plan:
- Idle flush: out_cnt=0, flush op1=0x8000_0100, op2=0x0000_0004 → ack same cycle; next cycle redirect_valid_o=1, pc=0x8000_0104; ready=1 → IDLE.
- Drain: 2 fetches issued, then flush op1=0x100, op2=0x20 → state DRAIN; 2 responses rsp_drop_o=1; redirect_valid_o=1 the cycle after the 2nd drop, pc=0x120.
- Back-to-back override: flush target 0x200 while in PEND with ready=0; next flush 0x300 → redirect_pc_o changes to 0x300; a single handshake delivers 0x300.
- Wrap/align: op1=0xFFFF_FFFE, op2=0x0000_0003 → pc=0x0000_0000.
- Same-cycle response and flush with out_cnt=1 and drop_cnt=0 → response not dropped; drop_cnt_next=0 → PEND.
- Reset during DRAIN (drop_cnt=1) → next cycle redirect_valid_o=0, rsp_drop_o=0, and no redirect afterwards; with E203_FLUSH_STAT_EN, counters read 0.
